// File: rtl/tank_render_multi.sv
// Multi-tank VGA renderer: 3-stage pipeline (centre calc, shape hit test,
// priority select) with a per-tank life/explosion state machine. The
// lowest-index covering tank wins the pixel and its index is reported.
module tank_render_multi #(
  parameter int          N_TANKS     = 4,
  parameter int          CELL        = 20,
  parameter int          ORIGIN      = 80,
  parameter int          HALF        = 10,
  parameter int          BARREL_HW   = 5,
  parameter int          EXPL_FRAMES = 16,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       frame_start,
  input  logic [10:0]                VGA_xpos,
  input  logic [10:0]                VGA_ypos,
  input  logic [5*N_TANKS-1:0]       x_rel_pos,
  input  logic [5*N_TANKS-1:0]       y_rel_pos,
  input  logic [N_TANKS-1:0]         tank_state,
  input  logic [N_TANKS-1:0]         tank_ide,
  input  logic [2*N_TANKS-1:0]       tank_dir,
  output logic [11:0]                VGA_data,
  output logic                       VGA_hit,
  output logic [$clog2(N_TANKS)-1:0] hit_idx
);

  localparam int IW = $clog2(N_TANKS);
  localparam logic [11:0] BLUE   = 12'h00F;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic signed [11:0] H = 12'(HALF);
  localparam logic signed [11:0] B = 12'(BARREL_HW);
  localparam logic signed [11:0] Z = '0;

  typedef enum logic [1:0] {DEAD = 2'd0, ALIVE = 2'd1, EXPL = 2'd2} tank_st_t;

  logic [10:0]            px_s1_reg, py_s1_reg;
  logic                   en_s1_reg, en_s2_reg;
  logic [N_TANKS-1:0]     hit_s2;
  logic [12*N_TANKS-1:0]  col_s2;
  logic [11:0]            data_next;
  logic                   hit_next;
  logic [IW-1:0]          idx_next;

  // S1/S2 shared pixel and enable pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px_s1_reg <= '0;
      py_s1_reg <= '0;
      en_s1_reg <= 1'b0;
      en_s2_reg <= 1'b0;
    end else begin
      px_s1_reg <= VGA_xpos;
      py_s1_reg <= VGA_ypos;
      en_s1_reg <= enable;
      en_s2_reg <= en_s1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_TANKS; gi++) begin : g_tank
      tank_st_t         st_reg, st_next, st_s1_reg;
      logic [7:0]       cnt_reg, cnt_next;
      logic             flash_s1_reg, ide_s1_reg;
      logic [1:0]       dir_s1_reg;
      logic [10:0]      cx_calc, cy_calc, cx_s1_reg, cy_s1_reg;
      logic signed [11:0] dx, dy;
      logic             dx_in_h, dx_in_b, dx_neg, dx_pos;
      logic             dy_in_h, dy_in_b, dy_neg, dy_pos;
      logic             shape, hit_calc;
      logic [11:0]      col_calc;
      logic             hit_s2_reg;
      logic [11:0]      col_s2_reg;

      assign cx_calc = 11'(x_rel_pos[5*gi +: 5]) * 11'(CELL) + 11'(ORIGIN);
      assign cy_calc = 11'(y_rel_pos[5*gi +: 5]) * 11'(CELL) + 11'(ORIGIN);

      // Life/explosion next state; respawn overrides the countdown
      always_comb begin
        st_next  = st_reg;
        cnt_next = cnt_reg;
        case (st_reg)
          DEAD:  if (tank_state[gi]) st_next = ALIVE;
          ALIVE: if (!tank_state[gi]) begin
                   st_next  = EXPL;
                   cnt_next = 8'(EXPL_FRAMES - 1);
                 end
          EXPL:  if (tank_state[gi]) st_next = ALIVE;
                 else if (frame_start) begin
                   if (cnt_reg == 8'd0) st_next = DEAD;
                   else                 cnt_next = cnt_reg - 8'd1;
                 end
          default: st_next = DEAD;
        endcase
      end

      // Life/explosion state register
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          st_reg  <= DEAD;
          cnt_reg <= '0;
        end else begin
          st_reg  <= st_next;
          cnt_reg <= cnt_next;
        end
      end

      // S1: snapshot of tank attributes travelling with the pixel
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          st_s1_reg    <= DEAD;
          flash_s1_reg <= 1'b0;
          ide_s1_reg   <= 1'b0;
          dir_s1_reg   <= '0;
          cx_s1_reg    <= '0;
          cy_s1_reg    <= '0;
        end else begin
          st_s1_reg    <= st_reg;
          flash_s1_reg <= cnt_reg[1];
          ide_s1_reg   <= tank_ide[gi];
          dir_s1_reg   <= tank_dir[2*gi +: 2];
          cx_s1_reg    <= cx_calc;
          cy_s1_reg    <= cy_calc;
        end
      end

      assign dx = $signed({1'b0, px_s1_reg}) - $signed({1'b0, cx_s1_reg});
      assign dy = $signed({1'b0, py_s1_reg}) - $signed({1'b0, cy_s1_reg});

      assign dx_in_h = (dx > -H) && (dx < H);
      assign dx_in_b = (dx > -B) && (dx < B);
      assign dx_neg  = (dx > -H) && (dx < Z);
      assign dx_pos  = (dx > Z)  && (dx < H);
      assign dy_in_h = (dy > -H) && (dy < H);
      assign dy_in_b = (dy > -B) && (dy < B);
      assign dy_neg  = (dy > -H) && (dy < Z);
      assign dy_pos  = (dy > Z)  && (dy < H);

      // S2: shape hit test; axis lines stay uncovered by design
      always_comb begin
        shape    = 1'b0;
        hit_calc = 1'b0;
        col_calc = YELLOW;
        case (dir_s1_reg)
          2'b00: shape = (dx_in_b && dy_neg) || (dx_in_h && dy_pos);
          2'b01: shape = (dx_in_h && dy_neg) || (dx_in_b && dy_pos);
          2'b10: shape = (dx_neg && dy_in_b) || (dx_pos && dy_in_h);
          default: shape = (dx_neg && dy_in_h) || (dx_pos && dy_in_b);
        endcase
        if (st_s1_reg == ALIVE) begin
          hit_calc = shape;
          col_calc = ide_s1_reg ? BLUE : RED;
        end else if (st_s1_reg == EXPL) begin
          hit_calc = flash_s1_reg && dx_in_h && dy_in_h;
        end
      end

      // S2 register of per-tank hit and colour
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hit_s2_reg <= 1'b0;
          col_s2_reg <= '0;
        end else begin
          hit_s2_reg <= hit_calc;
          col_s2_reg <= col_calc;
        end
      end

      assign hit_s2[gi]         = hit_s2_reg;
      assign col_s2[12*gi +: 12] = col_s2_reg;
    end
  endgenerate

  // S3: lowest index wins; disabled pixels show background
  always_comb begin
    data_next = BG_COLOR;
    hit_next  = 1'b0;
    idx_next  = '0;
    if (en_s2_reg) begin
      for (int i = N_TANKS - 1; i >= 0; i--) begin
        if (hit_s2[i]) begin
          data_next = col_s2[12*i +: 12];
          hit_next  = 1'b1;
          idx_next  = IW'(i);
        end
      end
    end
  end

  // S3 output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      VGA_data <= 12'h000;
      VGA_hit  <= 1'b0;
      hit_idx  <= '0;
    end else begin
      VGA_data <= data_next;
      VGA_hit  <= hit_next;
      hit_idx  <= idx_next;
    end
  end

endmodule

// File: tb/tb_tank_render_multi.sv
// Directed bench for tank_render_multi: streams pixels one per clock and
// compares each result three clocks later against hand-computed values.
module tb_tank_render_multi;
  localparam logic [11:0] BLUE = 12'h00F;
  localparam logic [11:0] RED  = 12'hF00;
  localparam logic [11:0] YEL  = 12'hFF0;
  localparam logic [11:0] BG   = 12'h000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] VGA_xpos = '0;
  logic [10:0] VGA_ypos = '0;
  logic [19:0] x_rel_pos = {5'd10, 5'd3, 5'd3, 5'd0};
  logic [19:0] y_rel_pos = {5'd10, 5'd3, 5'd3, 5'd0};
  logic [3:0]  tank_state = '0;
  logic [3:0]  tank_ide = '0;
  logic [7:0]  tank_dir = '0;
  logic [11:0] VGA_data;
  logic        VGA_hit;
  logic [1:0]  hit_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  q_v = '0;
  logic [11:0] q_d [3];
  logic        q_h [3];
  logic [1:0]  q_i [3];
  string       q_t [3];

  int          c_model;
  logic        expl_model;
  logic [7:0]  c_bits;
  logic        flash;

  tank_render_multi dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos),
    .x_rel_pos(x_rel_pos), .y_rel_pos(y_rel_pos),
    .tank_state(tank_state), .tank_ide(tank_ide), .tank_dir(tank_dir),
    .VGA_data(VGA_data), .VGA_hit(VGA_hit), .hit_idx(hit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one pixel, clock once, and check the pixel that entered three clocks ago
  task automatic step(input string tag, input int x, input int y, input logic en,
                      input logic v, input logic [11:0] ed, input logic eh, input logic [1:0] ei);
    VGA_xpos = 11'(x);
    VGA_ypos = 11'(y);
    enable   = en;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    for (int k = 2; k > 0; k--) begin
      q_d[k] = q_d[k-1]; q_h[k] = q_h[k-1]; q_i[k] = q_i[k-1]; q_t[k] = q_t[k-1];
    end
    q_v = {q_v[1:0], v};
    q_d[0] = ed; q_h[0] = eh; q_i[0] = ei; q_t[0] = tag;
    if (!rst_n) q_v = '0;
    if (q_v[2]) begin
      check({q_t[2], "_data"}, VGA_data, q_d[2]);
      check({q_t[2], "_hit"}, {11'd0, VGA_hit}, {11'd0, q_h[2]});
      check({q_t[2], "_idx"}, {10'd0, hit_idx}, {10'd0, q_i[2]});
      $display("pix %s data=%h hit=%0d idx=%0d", q_t[2], VGA_data, VGA_hit, hit_idx);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 0, 0, 1'b1, 1'b0, BG, 1'b0, 2'd0);
  endtask

  initial begin
    // Reset
    idle(2);
    check("rst_data", VGA_data, 12'h000);
    check("rst_hit", {11'd0, VGA_hit}, 12'd0);
    check("rst_idx", {10'd0, hit_idx}, 12'd0);
    rst_n = 1'b1;

    // T1: tank0 player, up, at (0,0) -> centre (80,80)
    tank_ide[0] = 1'b1; tank_dir[1:0] = 2'b00; tank_state[0] = 1'b1;
    idle(1);
    step("t1_barrel", 80, 75, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("t1_tip",    80, 70, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    step("t1_body",   72, 85, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("t1_corner", 72, 75, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    step("t1_axis",   80, 80, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    step("t1_edge_in",  89, 85, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("t1_edge_out", 90, 85, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    tank_dir[1:0] = 2'b01;
    step("dn_body",    80, 75, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("dn_barrel",  83, 85, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("dn_bar_out", 85, 85, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    tank_dir[1:0] = 2'b10;
    step("lf_barrel",  75, 80, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("lf_body",    85, 85, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("lf_bar_out", 75, 85, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    tank_dir[1:0] = 2'b11;
    step("rt_barrel",  85, 80, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("rt_body",    75, 75, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("rt_bar_in",  85, 76, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    tank_dir[1:0] = 2'b00;

    // T2: tanks 1 (enemy) and 2 (player) overlap at (3,3) -> centre (140,140)
    tank_ide[1] = 1'b0; tank_ide[2] = 1'b1; tank_state[2:1] = 2'b11;
    idle(1);
    step("t2_prio", 140, 145, 1'b1, 1'b1, RED, 1'b1, 2'd1);
    tank_state[1] = 1'b0;
    step("t2_last", 140, 145, 1'b1, 1'b1, RED, 1'b1, 2'd1);
    step("t2_expl", 140, 145, 1'b1, 1'b1, YEL, 1'b1, 2'd1);
    step("t2_sq",   131, 131, 1'b1, 1'b1, YEL, 1'b1, 2'd1);

    // T3: tank0 explodes, countdown over 16 frames
    tank_state[0] = 1'b0;
    step("t3_kill", 80, 80, 1'b1, 1'b1, BG,  1'b0, 2'd0);
    step("t3_c15",  80, 80, 1'b1, 1'b1, YEL, 1'b1, 2'd0);
    c_model = 15; expl_model = 1'b1;
    for (int k = 0; k < 17; k++) begin
      c_bits = 8'(c_model);
      flash = expl_model && c_bits[1];
      frame_start = 1'b1;
      step($sformatf("t3_f%0d_c%0d", k, c_model), 80, 80, 1'b1, 1'b1,
           flash ? YEL : BG, flash, 2'd0);
      if (c_model == 0) expl_model = 1'b0;
      else              c_model--;
    end
    frame_start = 1'b1;
    step("t3_dead0", 80, 80, 1'b1, 1'b1, BG, 1'b0, 2'd0);
    step("t3_dead1", 80, 80, 1'b1, 1'b1, BG, 1'b0, 2'd0);

    // T4: respawn during explosion beats the frame pulse
    tank_state[0] = 1'b1; idle(1);
    tank_state[0] = 1'b0; idle(1);
    for (int k = 0; k < 5; k++) begin
      frame_start = 1'b1;
      idle(1);
    end
    frame_start = 1'b1;
    step("t4_c10", 80, 80, 1'b1, 1'b1, YEL, 1'b1, 2'd0);
    tank_state[0] = 1'b1; frame_start = 1'b1;
    step("t4_c9",     80, 80, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    step("t4_barrel", 80, 75, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("t4_gap",    80, 80, 1'b1, 1'b1, BG,   1'b0, 2'd0);

    // T5: single disabled pixel among hits
    step("t5_a",   80, 75, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("t5_off", 72, 85, 1'b0, 1'b1, BG,   1'b0, 2'd0);
    step("t5_b",   72, 85, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("t5_c",   80, 75, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);

    // T6: reset mid-stream with one tank alive and one exploding
    tank_state[1] = 1'b1; idle(1);
    tank_state[1] = 1'b0; idle(1);
    step("t6_pre_yel",  140, 140, 1'b1, 1'b1, YEL,  1'b1, 2'd1);
    step("t6_pre_blue", 80, 75,   1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    for (int k = 0; k < 3; k++) step("t6_hold", 80, 75, 1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    rst_n = 1'b0;
    step("t6_rst", 80, 75, 1'b1, 1'b0, BG, 1'b0, 2'd0);
    check("t6_rst_data", VGA_data, 12'h000);
    check("t6_rst_hit", {11'd0, VGA_hit}, 12'd0);
    check("t6_rst_idx", {10'd0, hit_idx}, 12'd0);
    rst_n = 1'b1;
    step("t6_first",  80, 75,   1'b1, 1'b1, BG,   1'b0, 2'd0);
    step("t6_alive",  80, 75,   1'b1, 1'b1, BLUE, 1'b1, 2'd0);
    step("t6_t1dead", 140, 140, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    step("t6_t1sq",   131, 131, 1'b1, 1'b1, BG,   1'b0, 2'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
